// File: rtl/cordic_phase_feeder.sv
// Phase-accumulator NCO that folds each phase into the cordic's convergent range and paces start pulses.
// Optional NCO_ROUND_EN: round half up when scaling the folded phase to radians (default: floor).
module cordic_phase_feeder #(
    parameter int          CORDIC_LAT = 18,
    parameter logic [15:0] PI_Q14     = 16'd51472
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] freq_word,
    input  logic        phase_load,
    input  logic [15:0] phase_init,
    output logic        start,
    output logic [15:0] angle,
    output logic [1:0]  quad,
    output logic        res_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(CORDIC_LAT - 1);

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] angle_q, angle_d;
    logic [1:0]  quad_q, quad_d;
    logic        start_q, start_d;
    logic        res_valid_q, res_valid_d;
    logic        busy_q, busy_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [15:0]        p_bias;
    logic [1:0]         fold_quad;
    logic [15:0]        fold_rem;
    logic signed [31:0] rem_ext;
    logic signed [31:0] pi_ext;
    logic signed [31:0] prod;
    logic signed [31:0] prod_adj;
    logic [15:0]        angle_next;
    logic               unused_fold;

    // Quadrant centred on 0, pi/2, pi, 3pi/2; remainder is the signed offset within +-1/8 turn.
    always_comb begin
        p_bias    = phase_q + 16'h2000;
        fold_quad = p_bias[15:14];
        fold_rem  = phase_q - {fold_quad, 14'd0};
        rem_ext   = {{16{fold_rem[15]}}, fold_rem};
        pi_ext    = {16'd0, PI_Q14};
        prod      = rem_ext * pi_ext;
`ifdef NCO_ROUND_EN
        prod_adj  = prod + 32'sd8192;
`else
        prod_adj  = prod;
`endif
        // |result| <= 25736, so bits [29:14] carry the whole arithmetic shift.
        angle_next  = prod_adj[29:14];
        unused_fold = ^{p_bias[13:0], prod_adj[31:30], prod_adj[13:0]};
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        angle_d     = angle_q;
        quad_d      = quad_q;
        start_d     = 1'b0;
        res_valid_d = 1'b0;
        busy_d      = busy_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (en) begin
                    angle_d = angle_next;
                    quad_d  = fold_quad;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                phase_d = phase_q + freq_word;
                busy_d  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (res_valid_q) begin
                    if (en) begin
                        angle_d = angle_next;
                        quad_d  = fold_quad;
                        start_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        res_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (phase_load) begin
            phase_d = phase_init;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= 16'd0;
            angle_q     <= 16'd0;
            quad_q      <= 2'd0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            angle_q     <= angle_d;
            quad_q      <= quad_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign start     = start_q;
    assign angle     = angle_q;
    assign quad      = quad_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cordic_phase_feeder.sv
// Self-checking bench for cordic_phase_feeder: fold table, multi-cycle corner sequences, random run vs model.
module tb_cordic_phase_feeder;

    localparam int LAT = 18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] freq_word = 16'd0;
    logic        phase_load = 1'b0;
    logic [15:0] phase_init = 16'd0;
    logic        start;
    logic [15:0] angle;
    logic [1:0]  quad;
    logic        res_valid;
    logic        busy;

    cordic_phase_feeder #(.CORDIC_LAT(LAT), .PI_Q14(16'd51472)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .freq_word(freq_word),
        .phase_load(phase_load), .phase_init(phase_init),
        .start(start), .angle(angle), .quad(quad),
        .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] phase;
        int          ang_floor;
        int          ang_round;
        int          quad;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick(input int f, input int r);
`ifdef NCO_ROUND_EN
        return r;
`else
        return f;
`endif
    endfunction

    function automatic int ang_s();
        return int'($signed(angle));
    endfunction

    // Reference fold from the arithmetic definition: nearest quarter turn, signed offset, times pi.
    function automatic int ref_quad(input int p);
        return ((p + 8192) / 16384) % 4;
    endfunction

    function automatic int ref_angle(input int p);
        int q, r, num;
        q = ref_quad(p);
        r = p - q * 16384;
        if (r < 0) r += 65536;
        if (r >= 32768) r -= 65536;
        num = r * 51472;
`ifdef NCO_ROUND_EN
        num += 8192;
`endif
        return num >>> 14;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        phase_load = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        en = 1'b0;
        for (int k = 0; k < LAT + 4; k++) tick();
    endtask

    // model state for the random run
    bit m_active;
    int m_age;
    int m_p;
    int m_angle;
    int m_quad;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{16'h1555,  17156,  17156, 0};
        vecs[1]  = '{16'h2000, -25736, -25736, 1};
        vecs[2]  = '{16'h1FFF,  25732,  25733, 0};
        vecs[3]  = '{16'hFFF0,    -51,    -50, 0};
        vecs[4]  = '{16'h1000,  12868,  12868, 0};
        vecs[5]  = '{16'h6000, -25736, -25736, 2};
        vecs[6]  = '{16'hE000, -25736, -25736, 0};
        vecs[7]  = '{16'h5FFF,  25732,  25733, 1};
        vecs[8]  = '{16'hA000, -25736, -25736, 3};
        vecs[9]  = '{16'h0001,      3,      3, 0};
        vecs[10] = '{16'hFFFF,     -4,     -3, 0};

        // reset state
        #1;
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_angle", ang_s(), 0);
        chk("rst_quad", int'(quad), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // fold table: single operation per entry, latency and busy width
        for (int i = 0; i < 11; i++) begin
            int rv_at, busy_cnt, extra;
            phase_load = 1'b1;
            phase_init = vecs[i].phase;
            freq_word = 16'd0;
            tick();
            phase_load = 1'b0;
            en = 1'b1;
            tick();
            en = 1'b0;
            chk($sformatf("tbl%0d_start", i), int'(start), 1);
            chk($sformatf("tbl%0d_angle", i), ang_s(), pick(vecs[i].ang_floor, vecs[i].ang_round));
            chk($sformatf("tbl%0d_quad", i), int'(quad), vecs[i].quad);
            rv_at = -1;
            busy_cnt = 1;
            extra = 0;
            for (int k = 1; k <= LAT + 3; k++) begin
                tick();
                if (res_valid && rv_at < 0) rv_at = k;
                if (busy) busy_cnt++;
                if (start) extra++;
            end
            chk($sformatf("tbl%0d_latency", i), rv_at, LAT);
            chk($sformatf("tbl%0d_busy_cycles", i), busy_cnt, LAT + 1);
            chk($sformatf("tbl%0d_extra_start", i), extra, 0);
            chk($sformatf("tbl%0d_angle_hold", i), ang_s(), pick(vecs[i].ang_floor, vecs[i].ang_round));
        end

        // wrap through zero with en held: period and advancing phase
        begin
            int exp_ang[3];
            exp_ang[0] = pick(-51, -50);
            exp_ang[1] = 50;
            exp_ang[2] = pick(150, 151);
            phase_load = 1'b1;
            phase_init = 16'hFFF0;
            freq_word = 16'h0020;
            tick();
            phase_load = 1'b0;
            en = 1'b1;
            tick();
            chk("wrap0_start", int'(start), 1);
            chk("wrap0_angle", ang_s(), exp_ang[0]);
            chk("wrap0_quad", int'(quad), 0);
            for (int n = 1; n < 3; n++) begin
                int gap;
                gap = -1;
                for (int k = 1; k <= LAT + 5; k++) begin
                    tick();
                    if (start) begin
                        gap = k;
                        break;
                    end
                end
                chk($sformatf("wrap%0d_period", n), gap, LAT + 1);
                chk($sformatf("wrap%0d_angle", n), ang_s(), exp_ang[n]);
                chk($sformatf("wrap%0d_quad", n), int'(quad), 0);
            end
            freq_word = 16'd0;
            wait_idle();
        end

        // en dropped mid-operation, phase_load during WAIT leaves the in-flight op untouched
        begin
            int rv_at, starts;
            phase_load = 1'b1;
            phase_init = 16'h1555;
            tick();
            phase_load = 1'b0;
            en = 1'b1;
            tick();
            rv_at = -1;
            starts = 0;
            for (int k = 1; k <= LAT + 4; k++) begin
                en = (k < 5);
                phase_load = (k == 7);
                phase_init = 16'h1000;
                tick();
                if (res_valid && rv_at < 0) rv_at = k;
                if (start) starts++;
                if (k == 7) chk("drop_angle_inflight", ang_s(), 17156);
                if (k == LAT + 1) chk("drop_busy_after", int'(busy), 0);
                if (k == LAT) chk("drop_busy_rv", int'(busy), 1);
            end
            phase_load = 1'b0;
            chk("drop_latency", rv_at, LAT);
            chk("drop_no_restart", starts, 0);
            en = 1'b1;
            tick();
            chk("drop_next_start", int'(start), 1);
            chk("drop_next_angle", ang_s(), 12868);
            chk("drop_next_quad", int'(quad), 0);
            wait_idle();
        end

        // asynchronous reset in the middle of an operation
        begin
            int rv_at, early_rv;
            phase_load = 1'b1;
            phase_init = 16'h6000;
            freq_word = 16'h0100;
            tick();
            phase_load = 1'b0;
            en = 1'b1;
            tick();
            chk("arst_pre_quad", int'(quad), 2);
            tick();
            tick();
            tick();
            #2;
            rst_n = 1'b0;
            #1;
            chk("arst_start", int'(start), 0);
            chk("arst_busy", int'(busy), 0);
            chk("arst_angle", ang_s(), 0);
            chk("arst_quad", int'(quad), 0);
            tick();
            tick();
            chk("arst_hold_busy", int'(busy), 0);
            rst_n = 1'b1;
            freq_word = 16'd0;
            tick();
            chk("arst_restart", int'(start), 1);
            chk("arst_restart_angle", ang_s(), 0);
            chk("arst_restart_quad", int'(quad), 0);
            en = 1'b0;
            rv_at = -1;
            early_rv = 0;
            for (int k = 1; k <= LAT + 2; k++) begin
                tick();
                if (res_valid && rv_at < 0) rv_at = k;
                if (res_valid && k < LAT) early_rv++;
            end
            chk("arst_no_stale_rv", early_rv, 0);
            chk("arst_latency", rv_at, LAT);
            wait_idle();
        end

        // randomized run against the transaction-level model
        do_reset();
        m_active = 0;
        m_age = 0;
        m_p = 0;
        m_angle = 0;
        m_quad = 0;
        for (int c = 0; c < 900; c++) begin
            bit issue_now, adv;
            int np;
            en = ($urandom_range(0, 3) != 0);
            phase_load = ($urandom_range(0, 15) == 0);
            phase_init = 16'($urandom);
            freq_word = 16'($urandom);
            issue_now = (!m_active || m_age == LAT) && en;
            adv = m_active && m_age == 0;
            np = adv ? (m_p + int'(freq_word)) % 65536 : m_p;
            if (phase_load) np = int'(phase_init);
            if (issue_now) begin
                m_angle = ref_angle(m_p);
                m_quad = ref_quad(m_p);
                m_active = 1;
                m_age = 0;
            end else if (m_active) begin
                if (m_age == LAT) m_active = 0;
                else m_age++;
            end
            m_p = np;
            tick();
            chk($sformatf("rnd%0d_start", c), int'(start), int'(m_active && m_age == 0));
            chk($sformatf("rnd%0d_res_valid", c), int'(res_valid), int'(m_active && m_age == LAT));
            chk($sformatf("rnd%0d_busy", c), int'(busy), int'(m_active));
            chk($sformatf("rnd%0d_angle", c), ang_s(), m_angle);
            chk($sformatf("rnd%0d_quad", c), int'(quad), m_quad);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
